// File: rtl/i2s_stereo_rx.sv
// i2s_stereo_rx
//   Oversampled I2S receiver. SCLK, WS and SD are synchronised into the clk
//   domain and treated as data; a stereo word pair is reassembled into signed
//   parallel L/R samples for the downstream mid/side stage.
//
// Ports
//   clk        system clock, at least 4x the I2S bit clock
//   rst        asynchronous active-high reset
//   i2s_sclk   I2S bit clock (asynchronous to clk)
//   i2s_ws     I2S word select, 0 = left, 1 = right
//   i2s_sd     I2S serial data, MSB first, two's complement
//   L, R       signed left/right samples, held between updates
//   sample_ce  one-cycle pulse when a new L/R pair is presented
//   frame_err  one-cycle pulse when a completed word was shorter than DATA_W
//   locked     high once word framing has been acquired

module i2s_stereo_rx #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2s_sclk,
    input  logic              i2s_ws,
    input  logic              i2s_sd,
    output logic [DATA_W-1:0] L,
    output logic [DATA_W-1:0] R,
    output logic              sample_ce,
    output logic              frame_err,
    output logic              locked
);

    localparam int unsigned     CNT_W   = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [0:0] ST_SEEK = 1'b0;
    localparam logic [0:0] ST_RX   = 1'b1;

    // Input synchronisers; the MSB is the synchronised value
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sd_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ws_sync   <= '0;
            sd_sync   <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i2s_sclk};
            ws_sync   <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sd};
        end
    end

    // Registered rising-edge detector; ws/sd are registered alongside so the
    // sampled bit lines up with the cycle in which the edge strobe is high
    logic sclk_q;
    logic rise_q;
    logic ws_k;
    logic sd_k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= 1'b0;
            rise_q <= 1'b0;
            ws_k   <= 1'b0;
            sd_k   <= 1'b0;
        end else begin
            sclk_q <= sclk_sync[SYNC_STAGES-1];
            rise_q <= sclk_sync[SYNC_STAGES-1] & ~sclk_q;
            ws_k   <= ws_sync[SYNC_STAGES-1];
            sd_k   <= sd_sync[SYNC_STAGES-1];
        end
    end

    // Framing state
    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              ws_prev_q;
    logic              have_ws_q;   // ws_prev_q holds a real sample since reset
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] l_hold_q;
    logic              l_valid_q;

    logic              ws_edge_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [DATA_W-1:0] word_nxt_c;
    logic              short_c;

    // WS change relative to the previous bit marks the LSB of the current word
    always_comb begin
        ws_edge_c = have_ws_q & (ws_k != ws_prev_q);
    end

    // Word with the current bit inserted; bits past DATA_W are dropped
    always_comb begin
        word_nxt_c = word_q;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (32'(bit_cnt_q) == (DATA_W - 1 - i)) begin
                word_nxt_c[i] = sd_k;
            end
        end
        cnt_inc_c = (bit_cnt_q == CNT_MAX) ? CNT_MAX : bit_cnt_q + CNT_W'(1);
        short_c   = (32'(bit_cnt_q) + 32'd1) < DATA_W;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: lock on the first WS transition, then stay locked
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEEK: begin
                if (rise_q && ws_edge_c) begin
                    state_d = ST_RX;
                end
            end
            ST_RX: begin
                state_d = ST_RX;
            end
            default: begin
                state_d = ST_SEEK;
            end
        endcase
    end

    // Bit capture, word completion and output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_prev_q <= 1'b0;
            have_ws_q <= 1'b0;
            bit_cnt_q <= '0;
            word_q    <= '0;
            l_hold_q  <= '0;
            l_valid_q <= 1'b0;
            L         <= '0;
            R         <= '0;
            sample_ce <= 1'b0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
        end else begin
            sample_ce <= 1'b0;
            frame_err <= 1'b0;
            if (rise_q) begin
                ws_prev_q <= ws_k;
                have_ws_q <= 1'b1;
                if (state_q == ST_SEEK) begin
                    // The bit at the lock edge closes an unseen word: discard it
                    if (ws_edge_c) begin
                        bit_cnt_q <= '0;
                        word_q    <= '0;
                        locked    <= 1'b1;
                    end
                end else if (ws_edge_c) begin
                    if (short_c) begin
                        frame_err <= 1'b1;
                    end
                    if (!ws_prev_q) begin
                        l_hold_q  <= word_nxt_c;
                        l_valid_q <= 1'b1;
                    end else if (l_valid_q) begin
                        L         <= l_hold_q;
                        R         <= word_nxt_c;
                        sample_ce <= 1'b1;
                        l_valid_q <= 1'b0;
                    end
                    bit_cnt_q <= '0;
                    word_q    <= '0;
                end else begin
                    bit_cnt_q <= cnt_inc_c;
                    word_q    <= word_nxt_c;
                end
            end
        end
    end

endmodule
